// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline control sequencer.
//
// Resolves memory wait > branch flush > hazard stall each cycle and drives
// the pipeline-register freeze/flush/bubble controls combinationally. A
// registered FSM records the class of the previous cycle, a watchdog flags
// hazard stalls that run longer than MAX_STALL, and three saturating
// counters tally stall, flush and wait cycles.
//
// Ports:
//   clk, rst_n         core clock (rising edge), async active-low reset
//   hazard             ID-stage data-hazard request
//   branch_taken_EXE   taken branch resolved in EXE
//   mem_req_MEM        load/store active in MEM
//   mem_ready          memory completes the access this cycle
//   cnt_clr            synchronous clear of counters and stall_err
//   freeze_PC          hold PC
//   freeze_IF_ID       hold IF/ID register
//   flush_IF_ID        clear IF/ID register to NOP
//   bubble_ID_EXE      load NOP into ID/EXE register
//   freeze_all         hold ID/EXE, EXE/MEM, MEM/WB registers
//   state              debug: 0 RUN, 1 STALL, 2 WAIT (previous cycle's class)
//   stall_err          sticky watchdog error
//   stall_cnt, flush_cnt, wait_cnt   saturating event counters
module pipe_ctrl #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard,
    input  logic             branch_taken_EXE,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             freeze_PC,
    output logic             freeze_IF_ID,
    output logic             flush_IF_ID,
    output logic             bubble_ID_EXE,
    output logic             freeze_all,
    output logic [1:0]       state,
    output logic             stall_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int RL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    logic mem_wait;
    logic flush_c;
    logic stall_c;

    state_e            state_q,     state_d;
    logic [RL_W-1:0]   run_len_q,   run_len_d;
    logic              stall_err_q, stall_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;

    // Exactly one of mem_wait / flush_c / stall_c (or none) per cycle.
    assign mem_wait = mem_req_MEM & ~mem_ready;
    assign flush_c  = ~mem_wait & branch_taken_EXE;
    assign stall_c  = ~mem_wait & ~branch_taken_EXE & hazard;

    // Same-cycle control outputs. While reset is held the front end is
    // flushed so nothing stale enters the pipe when reset releases.
    always_comb begin
        freeze_PC     = 1'b0;
        freeze_IF_ID  = 1'b0;
        flush_IF_ID   = 1'b0;
        bubble_ID_EXE = 1'b0;
        freeze_all    = 1'b0;
        if (!rst_n) begin
            flush_IF_ID   = 1'b1;
            bubble_ID_EXE = 1'b1;
        end else if (mem_wait) begin
            freeze_PC    = 1'b1;
            freeze_IF_ID = 1'b1;
            freeze_all   = 1'b1;
        end else if (flush_c) begin
            flush_IF_ID   = 1'b1;
            bubble_ID_EXE = 1'b1;
        end else if (stall_c) begin
            freeze_PC     = 1'b1;
            freeze_IF_ID  = 1'b1;
            bubble_ID_EXE = 1'b1;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (mem_wait)
            state_d = ST_WAIT;
        else if (stall_c)
            state_d = ST_STALL;

        // Watchdog run length: a memory wait freezes the whole pipe, so an
        // interrupted hazard stall resumes with its count intact.
        run_len_d = '0;
        if (stall_c) begin
            if (run_len_q != RL_W'(MAX_STALL))
                run_len_d = run_len_q + RL_W'(1);
            else
                run_len_d = run_len_q;
        end else if (mem_wait) begin
            run_len_d = run_len_q;
        end

        stall_err_d = stall_err_q;
        if (cnt_clr)
            stall_err_d = 1'b0;
        else if (stall_c && (run_len_q == RL_W'(MAX_STALL)))
            stall_err_d = 1'b1;

        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            wait_cnt_d  = '0;
        end else begin
            stall_cnt_d = sat_inc(stall_cnt_q, stall_c);
            flush_cnt_d = sat_inc(flush_cnt_q, flush_c);
            wait_cnt_d  = sat_inc(wait_cnt_q,  mem_wait);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            run_len_q   <= '0;
            stall_err_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            stall_err_q <= stall_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_err = stall_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random traffic,
// checked through an expectation queue against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int CW   = 4;
    localparam int MAXS = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          hazard, branch_taken_EXE, mem_req_MEM, mem_ready, cnt_clr;
    logic          freeze_PC, freeze_IF_ID, flush_IF_ID, bubble_ID_EXE, freeze_all;
    logic [1:0]    state;
    logic          stall_err;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

    pipe_ctrl #(.CNT_W(CW), .MAX_STALL(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .hazard(hazard), .branch_taken_EXE(branch_taken_EXE),
        .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .freeze_PC(freeze_PC), .freeze_IF_ID(freeze_IF_ID),
        .flush_IF_ID(flush_IF_ID), .bubble_ID_EXE(bubble_ID_EXE),
        .freeze_all(freeze_all), .state(state), .stall_err(stall_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int fpc, fif, fl, bub, fall;
        int st, err, sc, fc, wc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: the class of the last cycle and plain integers.
    int m_last;   // 0 none/flush, 1 stall, 2 wait
    int m_run, m_err, m_sc, m_fc, m_wc;

    task automatic model_reset();
        m_last = 0; m_run = 0; m_err = 0; m_sc = 0; m_fc = 0; m_wc = 0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // One clock cycle of stimulus: drive inputs just after the edge, push the
    // expected outputs for this cycle, then advance the model over the next edge.
    task automatic step(input bit h, input bit b, input bit mq, input bit mr,
                        input bit clr, input bit rst);
        exp_t e;
        string kind;
        @(posedge clk);
        #1;
        hazard = h; branch_taken_EXE = b; mem_req_MEM = mq; mem_ready = mr;
        cnt_clr = clr; rst_n = !rst;
        if (rst) begin
            model_reset();
            e = '{fpc:0, fif:0, fl:1, bub:1, fall:0, st:0, err:0, sc:0, fc:0, wc:0};
            q.push_back(e);
        end else begin
            if (mq && !mr) kind = "wait";
            else if (b)    kind = "flush";
            else if (h)    kind = "stall";
            else           kind = "none";
            e.fpc  = (kind == "wait" || kind == "stall");
            e.fif  = e.fpc;
            e.fl   = (kind == "flush");
            e.bub  = (kind == "flush" || kind == "stall");
            e.fall = (kind == "wait");
            e.st = m_last; e.err = m_err; e.sc = m_sc; e.fc = m_fc; e.wc = m_wc;
            q.push_back(e);
            m_last = (kind == "wait") ? 2 : (kind == "stall") ? 1 : 0;
            if (clr) m_err = 0;
            else if (kind == "stall" && m_run == MAXS) m_err = 1;
            if (kind == "stall")      m_run = (m_run + 1 > MAXS) ? MAXS : m_run + 1;
            else if (kind != "wait")  m_run = 0;
            if (clr) begin
                m_sc = 0; m_fc = 0; m_wc = 0;
            end else begin
                if (kind == "stall" && m_sc < CMAX) m_sc++;
                if (kind == "flush" && m_fc < CMAX) m_fc++;
                if (kind == "wait"  && m_wc < CMAX) m_wc++;
            end
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("freeze_PC",     int'(freeze_PC),     e.fpc);
                chk("freeze_IF_ID",  int'(freeze_IF_ID),  e.fif);
                chk("flush_IF_ID",   int'(flush_IF_ID),   e.fl);
                chk("bubble_ID_EXE", int'(bubble_ID_EXE), e.bub);
                chk("freeze_all",    int'(freeze_all),    e.fall);
                chk("state",         int'(state),         e.st);
                chk("stall_err",     int'(stall_err),     e.err);
                chk("stall_cnt",     int'(stall_cnt),     e.sc);
                chk("flush_cnt",     int'(flush_cnt),     e.fc);
                chk("wait_cnt",      int'(wait_cnt),      e.wc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; hazard = 0; branch_taken_EXE = 0; mem_req_MEM = 0;
        mem_ready = 0; cnt_clr = 0;
        model_reset();

        // Reset held with noisy inputs.
        step(1, 0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Three-cycle hazard, then idle.
        repeat (3) step(1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);

        // Five-cycle hazard trips the watchdog; it stays set until cnt_clr.
        repeat (5) step(1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Hazard coincident with a taken branch: flush wins.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Stall, interrupted by a four-cycle memory wait, then resumed:
        // run length carries through the wait and trips the watchdog.
        repeat (3) step(1, 0, 0, 0, 0, 0);
        repeat (4) step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);

        // Flush counter saturation, then clear against a concurrent flush.
        repeat (20) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset in the middle of a wait with counters nonzero.
        repeat (3) step(0, 1, 0, 0, 0, 0);
        repeat (3) step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bit h, b, mq, mr, clr, rst;
            h   = ($urandom_range(0, 9) < 7);
            b   = ($urandom_range(0, 9) < 1);
            mq  = ($urandom_range(0, 9) < 3);
            mr  = $urandom_range(0, 1);
            clr = ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 199) < 1);
            step(h, b, mq, mr, clr, rst);
        end

        step(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
